alu_cmd_entry: RTL and testbench

Front-end command entry controller for the board-level ALU. It turns raw slide switches and two push buttons into a registered, stable operand/opcode pair with a valid/ready handshake into the ALU datapath. Each button is synchronized and debounced, and entry follows a two-phase sequence: operand first, then opcode. The block sits between the board I/O pins and the ALU inputs, replacing the direct switch-to-ALU wiring.

---
 rtl/alu_cmd_entry.sv | 204 ++++++++++++++++++++
 tb/tb_alu_cmd_entry.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_entry.sv
// -----------------------------------------------------------------------------
// alu_cmd_entry
//   Front-end command entry for the board-level ALU. Synchronizes the slide
//   switches and both push buttons, debounces the buttons into one-cycle press
//   events, and walks a two-phase entry (operand, then one-hot opcode) before
//   presenting a stable command to the ALU with a valid/ready handshake.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   sw         in  10   raw slide switches (asynchronous)
//   btn_enter  in   1   raw enter button, active high, bouncy
//   btn_clear  in   1   raw clear button, active high, bouncy
//   cmd_ready  in   1   ALU accepts the presented command
//   operand    out 10   registered operand, [9:5] = X, [4:0] = Y
//   opcode     out  6   registered one-hot opcode
//   cmd_valid  out  1   command presented (registered)
//   phase      out  2   FSM state encoding for LEDs
//   err        out  1   one-cycle pulse on a rejected opcode
// -----------------------------------------------------------------------------
module alu_cmd_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic       cmd_ready,
    output logic [9:0] operand,
    output logic [5:0] opcode,
    output logic       cmd_valid,
    output logic [1:0] phase,
    output logic       err
);

    typedef enum logic [1:0] {
        ENTER_OPND = 2'd0,
        ENTER_OPC  = 2'd1,
        ISSUE      = 2'd2,
        HOLD       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Index 0 = enter, index 1 = clear.
    localparam int BTN_ENTER = 0;
    localparam int BTN_CLEAR = 1;

    // True when exactly one bit of a 6-bit opcode field is set.
    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    logic [9:0]       sw_meta_r;
    logic [9:0]       sw_sync_r;
    logic [1:0]       btn_meta_r;
    logic [1:0]       btn_sync_r;
    logic [1:0]       deb_r;
    logic [1:0]       deb_d_r;
    logic [1:0]       ev_r;
    logic [CNT_W-1:0] cnt_r [0:1];

    state_t state_r;
    state_t next_s;
    logic   cap_opnd_s;
    logic   cap_opc_s;
    logic   err_s;
    logic   clr_s;

    // Two-flop synchronizers for the switches and both buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_r  <= 10'd0;
            sw_sync_r  <= 10'd0;
            btn_meta_r <= 2'b00;
            btn_sync_r <= 2'b00;
        end else begin
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= {btn_clear, btn_enter};
            btn_sync_r <= btn_meta_r;
        end
    end

    // Per-button debounce counter, debounced level and registered press pulse.
    // The level flips on the sample where the mismatch count has already hit
    // DEBOUNCE_CYCLES; the pulse is the registered rising edge of that level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            ev_r    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_r[i] != deb_r[i]) begin
                    if (cnt_r[i] == DEB_MAX) begin
                        deb_r[i] <= btn_sync_r[i];
                        cnt_r[i] <= '0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    end
                end else begin
                    cnt_r[i] <= '0;
                end
                deb_d_r[i] <= deb_r[i];
                ev_r[i]    <= deb_r[i] & ~deb_d_r[i];
            end
        end
    end

    // Next-state and capture decisions; clear overrides any enter event.
    always_comb begin
        next_s     = state_r;
        cap_opnd_s = 1'b0;
        cap_opc_s  = 1'b0;
        err_s      = 1'b0;
        clr_s      = ev_r[BTN_CLEAR];
        if (clr_s) begin
            next_s = ENTER_OPND;
        end else begin
            case (state_r)
                ENTER_OPND: begin
                    if (ev_r[BTN_ENTER]) begin
                        cap_opnd_s = 1'b1;
                        next_s     = ENTER_OPC;
                    end else begin
                        next_s = ENTER_OPND;
                    end
                end
                ENTER_OPC: begin
                    if (ev_r[BTN_ENTER]) begin
                        if (is_onehot6(sw_sync_r[5:0])) begin
                            cap_opc_s = 1'b1;
                            next_s    = ISSUE;
                        end else begin
                            err_s  = 1'b1;
                            next_s = ENTER_OPC;
                        end
                    end else begin
                        next_s = ENTER_OPC;
                    end
                end
                ISSUE: begin
                    // Enter presses are ignored until the ALU takes the command.
                    if (cmd_valid && cmd_ready) begin
                        next_s = HOLD;
                    end else begin
                        next_s = ISSUE;
                    end
                end
                HOLD: begin
                    // This press only rearms entry; it captures nothing.
                    if (ev_r[BTN_ENTER]) begin
                        next_s = ENTER_OPND;
                    end else begin
                        next_s = HOLD;
                    end
                end
                default: begin
                    next_s = ENTER_OPND;
                end
            endcase
        end
    end

    // State register and registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ENTER_OPND;
            operand   <= 10'd0;
            opcode    <= 6'd0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= next_s;
            cmd_valid <= (next_s == ISSUE);
            err       <= err_s;
            if (clr_s) begin
                operand <= 10'd0;
                opcode  <= 6'd0;
            end else begin
                if (cap_opnd_s) begin
                    operand <= sw_sync_r;
                end else begin
                    operand <= operand;
                end
                if (cap_opc_s) begin
                    opcode <= sw_sync_r[5:0];
                end else begin
                    opcode <= opcode;
                end
            end
        end
    end

    assign phase = state_r;

endmodule

// File: tb/tb_alu_cmd_entry.sv
module tb_alu_cmd_entry;

    localparam int D   = 16;
    // Negedges from driving a raw press until the resulting state is visible.
    localparam int LAT = D + 5;

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic       cmd_ready;
    logic [9:0] operand;
    logic [5:0] opcode;
    logic       cmd_valid;
    logic [1:0] phase;
    logic       err;

    int checks;
    int failures;

    alu_cmd_entry #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .cmd_ready(cmd_ready),
        .operand  (operand),
        .opcode   (opcode),
        .cmd_valid(cmd_valid),
        .phase    (phase),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        sw        = 10'd0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cmd_ready = 1'b0;

        // Reset state
        tick(3);
        chk("rst_operand", 32'(operand), 32'h000);
        chk("rst_opcode", 32'(opcode), 32'h00);
        chk("rst_valid", 32'(cmd_valid), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        tick(5);
        chk("idle_phase", 32'(phase), 32'h0);
        chk("idle_valid", 32'(cmd_valid), 32'h0);

        // Operand capture with exact press latency, long hold gives one event
        sw        = 10'b00011_00101;
        cmd_ready = 1'b1;
        tick(3);
        btn_enter = 1'b1;
        tick(LAT - 1);
        chk("opnd_early_phase", 32'(phase), 32'h0);
        tick(1);
        chk("opnd_phase", 32'(phase), 32'h1);
        chk("opnd_value", 32'(operand), 32'h065);
        tick(40 - LAT);
        chk("opnd_hold_phase", 32'(phase), 32'h1);
        btn_enter = 1'b0;
        tick(25);

        // Opcode capture, one-cycle valid with ready high, then HOLD
        sw        = 10'h001;
        btn_enter = 1'b1;
        tick(LAT);
        chk("issue_phase", 32'(phase), 32'h2);
        chk("issue_valid", 32'(cmd_valid), 32'h1);
        chk("issue_opcode", 32'(opcode), 32'h01);
        chk("issue_operand", 32'(operand), 32'h065);
        tick(1);
        chk("hold_phase", 32'(phase), 32'h3);
        chk("hold_valid", 32'(cmd_valid), 32'h0);
        chk("hold_opcode", 32'(opcode), 32'h01);
        tick(2);
        chk("hold_valid_later", 32'(cmd_valid), 32'h0);
        btn_enter = 1'b0;
        tick(25);

        // Bouncy enter in HOLD: one event, timed from the stable level, no capture
        sw = 10'h3FF;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            btn_enter = 1'b1;
            tick(3);
            btn_enter = 1'b0;
            tick(3);
        end
        btn_enter = 1'b1;
        tick(LAT - 1);
        chk("bounce_early_phase", 32'(phase), 32'h3);
        tick(1);
        chk("bounce_phase", 32'(phase), 32'h0);
        chk("bounce_nocap_operand", 32'(operand), 32'h065);
        chk("bounce_nocap_opcode", 32'(opcode), 32'h01);
        tick(20);
        chk("bounce_single_event", 32'(phase), 32'h0);
        btn_enter = 1'b0;
        tick(25);

        // Lone 10-cycle glitch is filtered
        btn_enter = 1'b1;
        tick(10);
        btn_enter = 1'b0;
        tick(40);
        chk("glitch_phase", 32'(phase), 32'h0);
        chk("glitch_operand", 32'(operand), 32'h065);

        // Operand, then a rejected two-hot opcode
        sw        = 10'h2AA;
        btn_enter = 1'b1;
        tick(LAT);
        chk("opnd2_phase", 32'(phase), 32'h1);
        chk("opnd2_value", 32'(operand), 32'h2AA);
        btn_enter = 1'b0;
        tick(25);
        sw        = 10'h003;
        btn_enter = 1'b1;
        tick(LAT - 1);
        chk("err_early", 32'(err), 32'h0);
        tick(1);
        chk("err_pulse", 32'(err), 32'h1);
        chk("err_phase", 32'(phase), 32'h1);
        chk("err_opcode_kept", 32'(opcode), 32'h01);
        tick(1);
        chk("err_one_cycle", 32'(err), 32'h0);
        chk("err_phase_after", 32'(phase), 32'h1);
        btn_enter = 1'b0;
        tick(25);

        // Retry with 6'b100000 while the ALU is not ready: command held
        cmd_ready = 1'b0;
        sw        = 10'h020;
        btn_enter = 1'b1;
        tick(LAT);
        chk("retry_phase", 32'(phase), 32'h2);
        chk("retry_valid", 32'(cmd_valid), 32'h1);
        chk("retry_opcode", 32'(opcode), 32'h20);
        btn_enter = 1'b0;
        tick(25);
        sw        = 10'h155;
        btn_enter = 1'b1;
        tick(25);
        chk("stall_valid", 32'(cmd_valid), 32'h1);
        chk("stall_phase", 32'(phase), 32'h2);
        chk("stall_operand", 32'(operand), 32'h2AA);
        chk("stall_opcode", 32'(opcode), 32'h20);
        btn_enter = 1'b0;
        tick(25);
        chk("stall_valid_end", 32'(cmd_valid), 32'h1);
        cmd_ready = 1'b1;
        tick(1);
        chk("ready_hold_phase", 32'(phase), 32'h3);
        chk("ready_valid_drop", 32'(cmd_valid), 32'h0);
        chk("ready_operand", 32'(operand), 32'h2AA);

        // Clear and enter together in HOLD: clear wins, nothing captured
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        tick(LAT);
        chk("clr_phase", 32'(phase), 32'h0);
        chk("clr_operand", 32'(operand), 32'h000);
        chk("clr_opcode", 32'(opcode), 32'h00);
        chk("clr_valid", 32'(cmd_valid), 32'h0);
        tick(10);
        chk("clr_no_capture_phase", 32'(phase), 32'h0);
        chk("clr_no_capture_operand", 32'(operand), 32'h000);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick(25);

        // Reset asserted mid-ISSUE drops cmd_valid without a clock edge
        sw        = 10'h065;
        btn_enter = 1'b1;
        tick(LAT);
        chk("pre_rst_phase1", 32'(phase), 32'h1);
        btn_enter = 1'b0;
        tick(25);
        cmd_ready = 1'b0;
        sw        = 10'h004;
        btn_enter = 1'b1;
        tick(LAT);
        chk("pre_rst_valid", 32'(cmd_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(cmd_valid), 32'h0);
        chk("async_rst_phase", 32'(phase), 32'h0);
        chk("async_rst_operand", 32'(operand), 32'h000);
        chk("async_rst_opcode", 32'(opcode), 32'h00);
        btn_enter = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_phase", 32'(phase), 32'h0);
        chk("post_rst_valid", 32'(cmd_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
